// File: rtl/nibble_fetch_sequencer_if.sv
// Multiplexed 4-bit bus between the fetch sequencer and program memory,
// including the cycle marker and bus-state index.
interface nibble_fetch_sequencer_if #(
    parameter int ADDR_NIBBLES = 3
);
    localparam int SW = $clog2(ADDR_NIBBLES + 5);

    logic [3:0]    d_i;
    logic [3:0]    d_o;
    logic          d_oe_o;
    logic          sync_o;
    logic [SW-1:0] state_o;

    modport master (input d_i, output d_o, d_oe_o, sync_o, state_o);
    modport slave  (output d_i, input d_o, d_oe_o, sync_o, state_o);
endinterface

// File: rtl/nibble_fetch_sequencer.sv
// Instruction-fetch sequencer for the nibble-bus CPU: runs the A/M/X bus cycle,
// assembles one- and two-word instructions and owns the PC/return stack.
module nibble_fetch_sequencer #(
    parameter int          ADDR_NIBBLES   = 3,
    parameter int          STACK_DEPTH    = 4,
    parameter logic [15:0] LONG_OPR_MASK  = 16'h00B2,
    parameter logic [15:0] LONG_EVEN_MASK = 16'h0004,
    localparam int         AW = 4 * ADDR_NIBBLES,
    localparam int         PW = $clog2(STACK_DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             phase_en_i,
    nibble_fetch_sequencer_if.master         bus_if,
    output logic                             instr_valid_o,
    output logic [3:0]                       opr_o,
    output logic [3:0]                       opa_o,
    output logic [7:0]                       operand_o,
    output logic [AW-1:0]                    pc_o,
    input  logic [2:0]                       pc_op_i,
    input  logic [AW-1:0]                    jump_addr_i,
    output logic [PW-1:0]                    sp_o,
    output logic                             overflow_o,
    output logic                             underflow_o
);
    localparam int SW = $clog2(ADDR_NIBBLES + 5);
    localparam int NW = $clog2(ADDR_NIBBLES);

    typedef enum logic [2:0] {
        ST_A, ST_M1, ST_M2, ST_X1, ST_X2, ST_X3
    } phase_e;

    phase_e          r_phase;
    phase_e          w_phase_nx;
    logic [NW-1:0]   r_anib;
    logic [NW-1:0]   w_anib_nx;

    logic [AW-1:0]   r_stk [STACK_DEPTH];
    logic [PW-1:0]   r_sp;
    logic            r_ovf;
    logic            r_unf;
    logic            r_pend;
    logic            r_cmpl;
    logic [3:0]      r_opr;
    logic [3:0]      r_opa;
    logic [7:0]      r_operand;
    logic [AW-1:0]   r_pc;

    logic [AW-1:0]   w_pc_act;
    logic [AW-1:0]   w_pc_inc;
    logic [AW-1:0]   w_pc_page;
    logic [AW-1:0]   w_pc_sh;
    logic [PW-1:0]   w_sp_inc;
    logic            w_long;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_phase <= ST_X3;
            r_anib  <= '0;
        end else begin
            r_phase <= w_phase_nx;
            r_anib  <= w_anib_nx;
        end
    end

    always_comb begin
        w_phase_nx = r_phase;
        w_anib_nx  = r_anib;
        if (phase_en_i) begin
            case (r_phase)
                ST_A: begin
                    if (r_anib == NW'(ADDR_NIBBLES - 1)) begin
                        w_phase_nx = ST_M1;
                        w_anib_nx  = '0;
                    end else begin
                        w_anib_nx = r_anib + 1'b1;
                    end
                end
                ST_M1:   w_phase_nx = ST_M2;
                ST_M2:   w_phase_nx = ST_X1;
                ST_X1:   w_phase_nx = ST_X2;
                ST_X2:   w_phase_nx = ST_X3;
                ST_X3: begin
                    w_phase_nx = ST_A;
                    w_anib_nx  = '0;
                end
                default: w_phase_nx = ST_X3;
            endcase
        end
    end

    always_comb begin
        w_pc_act        = r_stk[r_sp];
        w_pc_inc        = w_pc_act + 1'b1;
        w_pc_page       = w_pc_inc;
        w_pc_page[7:0]  = jump_addr_i[7:0];
        w_sp_inc        = r_sp + 1'b1;
        w_pc_sh         = w_pc_act >> {r_anib, 2'b00};
        w_long          = LONG_OPR_MASK[r_opr] | (LONG_EVEN_MASK[r_opr] & ~bus_if.d_i[0]);

        bus_if.d_oe_o   = 1'b0;
        bus_if.d_o      = '0;
        bus_if.sync_o   = 1'b0;
        bus_if.state_o  = '0;
        instr_valid_o   = 1'b0;
        case (r_phase)
            ST_A: begin
                bus_if.d_oe_o  = 1'b1;
                bus_if.d_o     = w_pc_sh[3:0];
                bus_if.state_o = SW'(r_anib);
            end
            ST_M1: bus_if.state_o = SW'(ADDR_NIBBLES);
            ST_M2: bus_if.state_o = SW'(ADDR_NIBBLES + 1);
            ST_X1: begin
                bus_if.state_o = SW'(ADDR_NIBBLES + 2);
                instr_valid_o  = r_cmpl;
            end
            ST_X2: bus_if.state_o = SW'(ADDR_NIBBLES + 3);
            ST_X3: begin
                bus_if.state_o = SW'(ADDR_NIBBLES + 4);
                bus_if.sync_o  = 1'b1;
            end
            default: bus_if.state_o = '0;
        endcase
    end

    // r_pend marks that the next M1/M2 pair is an operand; r_cmpl marks that
    // the current cycle finished an instruction and so owns the pc_op action.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stk     <= '{default: '0};
            r_sp      <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_pend    <= 1'b0;
            r_cmpl    <= 1'b0;
            r_opr     <= '0;
            r_opa     <= '0;
            r_operand <= '0;
            r_pc      <= '0;
        end else if (phase_en_i) begin
            case (r_phase)
                ST_M1: begin
                    if (r_pend) begin
                        r_operand[7:4] <= bus_if.d_i;
                    end else begin
                        r_opr     <= bus_if.d_i;
                        r_operand <= '0;
                    end
                end
                ST_M2: begin
                    if (r_pend) begin
                        r_operand[3:0] <= bus_if.d_i;
                        r_pend         <= 1'b0;
                        r_cmpl         <= 1'b1;
                    end else begin
                        r_opa  <= bus_if.d_i;
                        r_pc   <= w_pc_act;
                        r_pend <= w_long;
                        r_cmpl <= ~w_long;
                    end
                end
                ST_X1: begin
                    if (!r_cmpl) begin
                        r_stk[r_sp] <= w_pc_inc;
                    end else begin
                        case (pc_op_i)
                            3'd1: r_stk[r_sp] <= jump_addr_i;
                            3'd2: begin
                                r_stk[r_sp]     <= w_pc_inc;
                                r_stk[w_sp_inc] <= jump_addr_i;
                                r_sp            <= w_sp_inc;
                                if (r_sp == PW'(STACK_DEPTH - 1)) r_ovf <= 1'b1;
                            end
                            3'd3: begin
                                r_sp <= r_sp - 1'b1;
                                if (r_sp == '0) r_unf <= 1'b1;
                            end
                            3'd4:    r_stk[r_sp] <= w_pc_page;
                            default: r_stk[r_sp] <= w_pc_inc;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign opr_o       = r_opr;
    assign opa_o       = r_opa;
    assign operand_o   = r_operand;
    assign pc_o        = r_pc;
    assign sp_o        = r_sp;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;

endmodule
